// File: rtl/unidade_de_busca_if.sv
// Fetch-stage bundle between the sequencing unit (master) and the instruction memory / datapath (slave).
// With PASSO_A_PASSO_EN defined the bundle also carries the single-step mode select.
interface unidade_de_busca_if;
    logic [31:0] instrucao;
    logic        condicao;
    logic [31:0] dadoRegistrador;
    logic        entradaConfirmada;
`ifdef PASSO_A_PASSO_EN
    logic        modoPasso;
`endif
    logic [31:0] endereco;
    logic        habilitaExecucao;
    logic        parado;
    logic        aguardandoEntrada;
    logic [31:0] contadorInstrucoes;

`ifdef PASSO_A_PASSO_EN
    modport master (
        input  instrucao, condicao, dadoRegistrador, entradaConfirmada, modoPasso,
        output endereco, habilitaExecucao, parado, aguardandoEntrada, contadorInstrucoes
    );
    modport slave (
        output instrucao, condicao, dadoRegistrador, entradaConfirmada, modoPasso,
        input  endereco, habilitaExecucao, parado, aguardandoEntrada, contadorInstrucoes
    );
`else
    modport master (
        input  instrucao, condicao, dadoRegistrador, entradaConfirmada,
        output endereco, habilitaExecucao, parado, aguardandoEntrada, contadorInstrucoes
    );
    modport slave (
        output instrucao, condicao, dadoRegistrador, entradaConfirmada,
        input  endereco, habilitaExecucao, parado, aguardandoEntrada, contadorInstrucoes
    );
`endif
endinterface

// File: rtl/unidade_de_busca.sv
// Fetch/sequencing stage: program counter, control-flow decode and commit gating.
// Optional single-step mode is compiled in with the PASSO_A_PASSO_EN macro.
module unidade_de_busca #(
    parameter logic [31:0] END_INICIAL    = 32'd1,
    parameter logic [4:0]  OP_DESVIO_COND = 5'd12,
    parameter logic [4:0]  OP_SALTO       = 5'd16,
    parameter logic [4:0]  OP_PARADA      = 5'd18,
    parameter logic [4:0]  OP_ENTRADA     = 5'd19,
    parameter logic [4:0]  OP_SALTO_REG   = 5'd27
) (
    input  logic               clock,
    input  logic               reset,
    unidade_de_busca_if.master bus
);

    typedef enum logic [1:0] {
        INICIO         = 2'd0,
        EXECUTA        = 2'd1,
        ESPERA_ENTRADA = 2'd2,
        PARADO         = 2'd3
    } estado_t;

    estado_t     r_estado;
    estado_t     w_prox_estado;
    logic [31:0] r_pc;
    logic [31:0] w_pc_prox;
    logic [31:0] r_contador;
    logic        r_sinc1;
    logic        r_sinc2;
    logic        r_sinc_ant;
    logic        w_conf_p;
    logic        w_avanca;
    logic [4:0]  w_op;
    logic [31:0] w_pc_mais1;
    logic        w_hab;
    logic        w_parado;
    logic        w_aguard;

    assign w_op       = bus.instrucao[31:27];
    assign w_pc_mais1 = r_pc + 32'd1;
    assign w_conf_p   = r_sinc2 & ~r_sinc_ant;

    // In step mode EXECUTA may only advance on a confirm pulse.
`ifdef PASSO_A_PASSO_EN
    assign w_avanca = ~bus.modoPasso | w_conf_p;
`else
    assign w_avanca = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc1    <= 1'b0;
            r_sinc2    <= 1'b0;
            r_sinc_ant <= 1'b0;
        end else begin
            r_sinc1    <= bus.entradaConfirmada;
            r_sinc2    <= r_sinc1;
            r_sinc_ant <= r_sinc2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= INICIO;
            r_pc       <= END_INICIAL;
            r_contador <= 32'd0;
        end else begin
            r_estado <= w_prox_estado;
            r_pc     <= w_pc_prox;
            if (w_hab) begin
                r_contador <= r_contador + 32'd1;
            end
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        w_pc_prox     = r_pc;
        case (r_estado)
            INICIO: begin
                w_prox_estado = EXECUTA;
            end
            EXECUTA: begin
                if (w_avanca) begin
                    case (w_op)
                        OP_SALTO:       w_pc_prox = {5'b0, bus.instrucao[26:0]};
                        OP_DESVIO_COND: w_pc_prox = bus.condicao ? {15'b0, bus.instrucao[16:0]} : w_pc_mais1;
                        OP_SALTO_REG:   w_pc_prox = bus.dadoRegistrador;
                        OP_PARADA:      w_prox_estado = PARADO;
                        OP_ENTRADA:     w_prox_estado = ESPERA_ENTRADA;
                        default:        w_pc_prox = w_pc_mais1;
                    endcase
                end
            end
            ESPERA_ENTRADA: begin
                if (w_conf_p) begin
                    w_pc_prox     = w_pc_mais1;
                    w_prox_estado = EXECUTA;
                end
            end
            PARADO: begin
                w_prox_estado = PARADO;
            end
            default: begin
                w_prox_estado = INICIO;
            end
        endcase
    end

    always_comb begin
        w_hab    = 1'b0;
        w_parado = 1'b0;
        w_aguard = 1'b0;
        case (r_estado)
            EXECUTA: begin
                case (w_op)
                    OP_PARADA, OP_ENTRADA: w_hab = 1'b0;
                    default:               w_hab = w_avanca;
                endcase
            end
            ESPERA_ENTRADA: begin
                w_aguard = 1'b1;
                w_hab    = w_conf_p;
            end
            PARADO: begin
                w_parado = 1'b1;
            end
            default: begin
                w_hab = 1'b0;
            end
        endcase
    end

    assign bus.endereco           = r_pc;
    assign bus.habilitaExecucao   = w_hab;
    assign bus.parado             = w_parado;
    assign bus.aguardandoEntrada  = w_aguard;
    assign bus.contadorInstrucoes = r_contador;

endmodule
